mem_arb: RTL



---
 rtl/mem_arb_if.sv | 49 ++++
 rtl/mem_arb.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_arb_if.sv
// Bus bundle between mem_arb, its three requesters and the RAM port.
// The master modport is the arbiter's view, and the slave modport is the environment's view.
interface mem_arb_if;
  logic        cpu_en;
  logic        cpu_wr;
  logic        cpu_ben;
  logic [19:0] cpu_adr;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        cpu_wait;

  logic        vid_req;
  logic [19:0] vid_adr;
  logic        vid_ack;

  logic        dma_req;
  logic        dma_wr;
  logic [19:0] dma_adr;
  logic [31:0] dma_din;
  logic        dma_ack;

  logic [31:0] rd_data;

  logic        mem_en;
  logic        mem_wr;
  logic        mem_ben;
  logic [19:0] mem_adr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_wait;

  modport master (
    input  cpu_en, cpu_wr, cpu_ben, cpu_adr, cpu_din,
    input  vid_req, vid_adr,
    input  dma_req, dma_wr, dma_adr, dma_din,
    input  mem_dout, mem_wait,
    output cpu_dout, cpu_wait, vid_ack, dma_ack, rd_data,
    output mem_en, mem_wr, mem_ben, mem_adr, mem_din
  );

  modport slave (
    output cpu_en, cpu_wr, cpu_ben, cpu_adr, cpu_din,
    output vid_req, vid_adr,
    output dma_req, dma_wr, dma_adr, dma_din,
    output mem_dout, mem_wait,
    input  cpu_dout, cpu_wait, vid_ack, dma_ack, rd_data,
    input  mem_en, mem_wr, mem_ben, mem_adr, mem_din
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: shares one RAM port between CPU, video fetcher and DMA, one transaction at a time.
// Define MEM_ARB_DMA_EN to enable the DMA requester; otherwise the DMA port is inert.
module mem_arb #(
  parameter int VID_BURST = 4
) (
  input logic       clk,
  input logic       rst_n,
  mem_arb_if.master bus
);

  typedef enum logic       {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {G_NONE, G_CPU, G_VID, G_DMA} grant_t;

  localparam logic [3:0] BURST = 4'(VID_BURST);

  state_t     state, state_nx;
  grant_t     grant, grant_nx;
  logic [3:0] vid_cnt, vid_cnt_nx;
  logic       dma_pend;
  logic       other_pend;
  logic       cpu_wins;
  logic       busy;
  logic       done;

`ifdef MEM_ARB_DMA_EN
  typedef enum logic {RR_CPU, RR_DMA} rr_t;
  rr_t rr, rr_nx;

  assign dma_pend = bus.dma_req;
  assign cpu_wins = bus.cpu_en & (~dma_pend | (rr == RR_CPU));
`else
  logic unused_dma;

  assign unused_dma = ^{bus.dma_req, bus.dma_wr, bus.dma_adr, bus.dma_din};
  assign dma_pend   = 1'b0;
  assign cpu_wins   = bus.cpu_en;
`endif

  assign other_pend = bus.cpu_en | dma_pend;
  assign busy       = (state == BUSY);
  assign done       = busy & ~bus.mem_wait;

  // NOTE: state registers use <= so every flop samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= G_NONE;
      vid_cnt <= '0;
`ifdef MEM_ARB_DMA_EN
      rr      <= RR_CPU;
`endif
    end else begin
      state   <= state_nx;
      grant   <= grant_nx;
      vid_cnt <= vid_cnt_nx;
`ifdef MEM_ARB_DMA_EN
      rr      <= rr_nx;
`endif
    end
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_nx   = state;
    grant_nx   = grant;
    vid_cnt_nx = vid_cnt;
`ifdef MEM_ARB_DMA_EN
    rr_nx      = rr;
`endif
    case (state)
      IDLE: begin
        if (bus.vid_req && !((vid_cnt == BURST) && other_pend)) begin
          grant_nx = G_VID;
          if (!other_pend)
            vid_cnt_nx = '0;
          else if (vid_cnt < BURST)
            vid_cnt_nx = vid_cnt + 4'd1;
        end else if (cpu_wins) begin
          grant_nx   = G_CPU;
          vid_cnt_nx = '0;
`ifdef MEM_ARB_DMA_EN
          rr_nx      = RR_DMA;
`endif
        end else if (dma_pend) begin
          grant_nx   = G_DMA;
          vid_cnt_nx = '0;
`ifdef MEM_ARB_DMA_EN
          rr_nx      = RR_CPU;
`endif
        end
        if (grant_nx != G_NONE)
          state_nx = BUSY;
      end
      BUSY: begin
        if (done) begin
          state_nx = IDLE;
          grant_nx = G_NONE;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = G_NONE;
      end
    endcase
  end

  // The memory port is a plain mux of the owner; grant is NONE whenever the FSM is idle.
  always_comb begin
    bus.mem_en  = busy;
    bus.mem_wr  = 1'b0;
    bus.mem_ben = 1'b0;
    bus.mem_adr = '0;
    bus.mem_din = '0;
    case (grant)
      G_CPU: begin
        bus.mem_wr  = bus.cpu_wr;
        bus.mem_ben = bus.cpu_ben;
        bus.mem_adr = bus.cpu_adr;
        bus.mem_din = bus.cpu_din;
      end
      G_VID: begin
        bus.mem_adr = bus.vid_adr;
      end
`ifdef MEM_ARB_DMA_EN
      G_DMA: begin
        bus.mem_wr  = bus.dma_wr;
        bus.mem_adr = bus.dma_adr;
        bus.mem_din = bus.dma_din;
      end
`endif
      default: ;
    endcase
  end

  assign bus.cpu_dout = bus.mem_dout;
  assign bus.rd_data  = bus.mem_dout;
  assign bus.vid_ack  = done & (grant == G_VID);
  assign bus.cpu_wait = bus.cpu_en & ~(done & (grant == G_CPU));

`ifdef MEM_ARB_DMA_EN
  assign bus.dma_ack = done & (grant == G_DMA);
`else
  assign bus.dma_ack = 1'b0;
`endif

endmodule
